// File: rtl/cgra_im_config_loader.sv
// DTL slave that streams host configuration bursts into the CGRA decoder and
// immediate instruction memories, and holds the compute core in reset until the host signals done.
module cgra_im_config_loader #(
   parameter int INTERFACE_WIDTH       = 32,
   parameter int INTERFACE_ADDR_WIDTH  = 32,
   parameter int INTERFACE_BLOCK_WIDTH = 5,
   parameter int I_WIDTH               = 12,
   parameter int I_IMM_WIDTH           = 33,
   parameter int IM_MEM_ADDR_WIDTH     = 8,
   parameter int NUM_ID                = 5,
   parameter int NUM_IMM               = 1
) (
   input  logic                             iClk,
   input  logic                             iReset,
   input  logic                             iDTL_Loader_CommandValid,
   output logic                             oDTL_Loader_CommandAccept,
   input  logic                             iDTL_Loader_CommandReadWrite,
   input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Loader_Address,
   input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_Loader_BlockSize,
   input  logic                             iDTL_Loader_WriteValid,
   output logic                             oDTL_Loader_WriteAccept,
   input  logic [INTERFACE_WIDTH-1:0]       iDTL_Loader_WriteData,
   input  logic [3:0]                       iDTL_Loader_WriteEnable,
   input  logic                             iDTL_Loader_WriteLast,
   output logic                             oDTL_Loader_ReadValid,
   input  logic                             iDTL_Loader_ReadAccept,
   output logic [INTERFACE_WIDTH-1:0]       oDTL_Loader_ReadData,
   output logic                             oDTL_Loader_ReadLast,
   output logic [NUM_ID+NUM_IMM-1:0]        oIM_WriteEnable,
   output logic [IM_MEM_ADDR_WIDTH-1:0]     oIM_WriteAddress,
   output logic [I_WIDTH-1:0]               oIM_WriteData,
   output logic [I_IMM_WIDTH-1:0]           oIM_WriteData_IMM,
   output logic                             oConfigDone,
   output logic                             oCoreReset
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WR   = 2'd1;
   localparam logic [1:0] ST_RD   = 2'd2;
   localparam int         WAW     = INTERFACE_ADDR_WIDTH - 2;
   localparam int         NUM_IM  = NUM_ID + NUM_IMM;
   localparam logic [4:0] NUM_ID_L = 5'(NUM_ID);
   localparam logic [4:0] NUM_IM_L = 5'(NUM_IM);

   logic [1:0]                       state_r, stateNext_s;
   logic [INTERFACE_BLOCK_WIDTH-1:0] beatCnt_r, beatCntNext_s;
   logic [WAW-1:0]                   wordAddr_r, wordAddrNext_s;
   logic                             done_r, doneNext_s;
   logic                             error_r, errorNext_s;
   logic                             stageValid_r, stageValidNext_s;
   logic [31:0]                      stageData_r, stageDataNext_s;
   logic [IM_MEM_ADDR_WIDTH-1:0]     stageIdx_r, stageIdxNext_s;
   logic [NUM_IM-1:0]                imWe_r, imWeNext_s;
   logic [IM_MEM_ADDR_WIDTH-1:0]     imAddr_r, imAddrNext_s;
   logic [I_WIDTH-1:0]               imData_r, imDataNext_s;
   logic [I_IMM_WIDTH-1:0]           imDataImm_r, imDataImmNext_s;
   logic                             coreReset_r;

   logic                             isCtrl_s;
   logic [3:0]                       memSel_s;
   logic [4:0]                       selExt_s;
   logic [17:0]                      wordField_s;
   logic [IM_MEM_ADDR_WIDTH-1:0]     immIdx_s;
   logic                             fullWord_s;
   logic                             unusedInputs_s;

   assign isCtrl_s    = wordAddr_r[WAW-1];
   assign memSel_s    = wordAddr_r[21:18];
   assign selExt_s    = {1'b0, memSel_s};
   assign wordField_s = wordAddr_r[17:0];
   assign immIdx_s    = wordField_s[IM_MEM_ADDR_WIDTH:1];
   assign fullWord_s  = (iDTL_Loader_WriteEnable == 4'hF);
   assign unusedInputs_s = ^{iDTL_Loader_WriteLast, iDTL_Loader_Address[1:0]};

   assign oDTL_Loader_CommandAccept = iReset & iDTL_Loader_CommandValid & (state_r == ST_IDLE);
   assign oDTL_Loader_WriteAccept   = (state_r == ST_WR);
   assign oDTL_Loader_ReadValid     = (state_r == ST_RD);
   assign oDTL_Loader_ReadLast      = (state_r == ST_RD) && (beatCnt_r == '0);
   assign oDTL_Loader_ReadData      = ((state_r == ST_RD) && isCtrl_s) ?
      {{(INTERFACE_WIDTH-3){1'b0}}, error_r, stageValid_r, done_r} : {INTERFACE_WIDTH{1'b0}};

   assign oIM_WriteEnable   = imWe_r;
   assign oIM_WriteAddress  = imAddr_r;
   assign oIM_WriteData     = imData_r;
   assign oIM_WriteData_IMM = imDataImm_r;
   assign oConfigDone       = done_r;
   assign oCoreReset        = coreReset_r;

   // Next-state logic: burst sequencing, beat decode and IM commit/staging.
   always_comb begin
      stateNext_s      = state_r;
      beatCntNext_s    = beatCnt_r;
      wordAddrNext_s   = wordAddr_r;
      doneNext_s       = done_r;
      errorNext_s      = error_r;
      stageValidNext_s = stageValid_r;
      stageDataNext_s  = stageData_r;
      stageIdxNext_s   = stageIdx_r;
      imWeNext_s       = '0;
      imAddrNext_s     = imAddr_r;
      imDataNext_s     = imData_r;
      imDataImmNext_s  = imDataImm_r;
      case (state_r)
         ST_IDLE: begin
            if (iDTL_Loader_CommandValid) begin
               beatCntNext_s  = iDTL_Loader_BlockSize;
               wordAddrNext_s = iDTL_Loader_Address[INTERFACE_ADDR_WIDTH-1:2];
               stateNext_s    = iDTL_Loader_CommandReadWrite ? ST_RD : ST_WR;
            end else begin
               stateNext_s = ST_IDLE;
            end
         end
         ST_WR: begin
            if (iDTL_Loader_WriteValid) begin
               wordAddrNext_s = wordAddr_r + WAW'(1);
               if (beatCnt_r == '0) begin
                  stateNext_s = ST_IDLE;
               end else begin
                  beatCntNext_s = beatCnt_r - INTERFACE_BLOCK_WIDTH'(1);
               end
               if (isCtrl_s) begin
                  // Clear has priority over setting done when both bits are written.
                  if (!fullWord_s) begin
                     errorNext_s = 1'b1;
                  end else if (iDTL_Loader_WriteData[1]) begin
                     doneNext_s       = 1'b0;
                     errorNext_s      = 1'b0;
                     stageValidNext_s = 1'b0;
                  end else if (iDTL_Loader_WriteData[0]) begin
                     doneNext_s = 1'b1;
                  end else begin
                     doneNext_s = done_r;
                  end
               end else if (!fullWord_s || (selExt_s >= NUM_IM_L) || done_r) begin
                  errorNext_s = 1'b1;
               end else if (selExt_s < NUM_ID_L) begin
                  imWeNext_s   = {{(NUM_IM-1){1'b0}}, 1'b1} << memSel_s;
                  imAddrNext_s = wordField_s[IM_MEM_ADDR_WIDTH-1:0];
                  imDataNext_s = iDTL_Loader_WriteData[I_WIDTH-1:0];
               end else if (!wordField_s[0]) begin
                  stageValidNext_s = 1'b1;
                  stageDataNext_s  = iDTL_Loader_WriteData[31:0];
                  stageIdxNext_s   = immIdx_s;
               end else if (stageValid_r && (stageIdx_r == immIdx_s)) begin
                  imWeNext_s       = {{(NUM_IM-1){1'b0}}, 1'b1} << memSel_s;
                  imAddrNext_s     = immIdx_s;
                  imDataImmNext_s  = {iDTL_Loader_WriteData[I_IMM_WIDTH-33:0], stageData_r};
                  stageValidNext_s = 1'b0;
               end else begin
                  errorNext_s = 1'b1;
               end
            end else begin
               stateNext_s = ST_WR;
            end
         end
         ST_RD: begin
            if (iDTL_Loader_ReadAccept) begin
               wordAddrNext_s = wordAddr_r + WAW'(1);
               if (beatCnt_r == '0) begin
                  stateNext_s = ST_IDLE;
               end else begin
                  beatCntNext_s = beatCnt_r - INTERFACE_BLOCK_WIDTH'(1);
               end
            end else begin
               stateNext_s = ST_RD;
            end
         end
         default: begin
            stateNext_s = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any burst and clears all status.
   always_ff @(posedge iClk) begin
      if (!iReset) begin
         state_r      <= ST_IDLE;
         beatCnt_r    <= '0;
         wordAddr_r   <= '0;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
         stageValid_r <= 1'b0;
         stageData_r  <= '0;
         stageIdx_r   <= '0;
         imWe_r       <= '0;
         imAddr_r     <= '0;
         imData_r     <= '0;
         imDataImm_r  <= '0;
         coreReset_r  <= 1'b0;
      end else begin
         state_r      <= stateNext_s;
         beatCnt_r    <= beatCntNext_s;
         wordAddr_r   <= wordAddrNext_s;
         done_r       <= doneNext_s;
         error_r      <= errorNext_s;
         stageValid_r <= stageValidNext_s;
         stageData_r  <= stageDataNext_s;
         stageIdx_r   <= stageIdxNext_s;
         imWe_r       <= imWeNext_s;
         imAddr_r     <= imAddrNext_s;
         imData_r     <= imDataNext_s;
         imDataImm_r  <= imDataImmNext_s;
         coreReset_r  <= doneNext_s;
      end
   end
endmodule
